// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: ALU op codes, register index
// width, the zero register and the EX-stage control bundle.
package mips_pkg;

   localparam int REGW = 5;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_CLR = 4'b1111;

   localparam logic [REGW-1:0] REG_ZERO = 5'd0;

   // Control bits carried with an instruction through EX
   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [3:0] alusel;
   } ex_ctrl_t;

   // A bubble: no side effects, ALU told to clear
   localparam ex_ctrl_t CTRL_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0,
                                        memwrite: 1'b0, alusel: ALU_CLR};

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// MEM/WB results are taken only when that stage writes a non-zero register
// matching the index; MEM is newer than WB so it wins.
module fwd_mux #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input  logic [REGW-1:0]  idx,
   input  logic [WIDTH-1:0] reg_val,
   input  logic             mem_regwrite,
   input  logic [REGW-1:0]  mem_dst,
   input  logic [WIDTH-1:0] mem_result,
   input  logic             wb_regwrite,
   input  logic [REGW-1:0]  wb_dst,
   input  logic [WIDTH-1:0] wb_result,
   output logic [WIDTH-1:0] val
);

   localparam logic [REGW-1:0] ZERO_IDX = {REGW{1'b0}};

   // Pick the newest producer of idx, falling back to the captured regfile value
   always_comb begin
      val = reg_val;
      if (mem_regwrite && (mem_dst != ZERO_IDX) && (mem_dst == idx)) begin
         val = mem_result;
      end else if (wb_regwrite && (wb_dst != ZERO_IDX) && (wb_dst == idx)) begin
         val = wb_result;
      end else begin
         val = reg_val;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select for the MIPS datapath.
// Captures decoded operands/control, detects hazards against EX (and MEM when
// forwarding is off) and inserts bubbles while ID is held.
// Build option: define FORWARDING_EN to forward EX/MEM and MEM/WB results
// onto the operands and stall only on load-use; otherwise operands come
// straight from the captured regfile values and any RAW hazard with EX or
// MEM stalls.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REGW-1:0]  id_rs,
   input  logic [REGW-1:0]  id_rt,
   input  logic [REGW-1:0]  id_dst,
   input  logic [WIDTH-1:0] id_rs_val,
   input  logic [WIDTH-1:0] id_rt_val,
   input  logic [WIDTH-1:0] id_imm,
   input  logic             id_alusrc,
   input  logic [3:0]       id_alusel,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             id_memwrite,
   input  logic             flush,
   input  logic             mem_regwrite,
   input  logic [REGW-1:0]  mem_dst,
   input  logic [WIDTH-1:0] mem_result,
   input  logic             wb_regwrite,
   input  logic [REGW-1:0]  wb_dst,
   input  logic [WIDTH-1:0] wb_result,
   output logic             id_stall,
   output logic             ex_valid,
   output logic [WIDTH-1:0] ex_a,
   output logic [WIDTH-1:0] ex_b,
   output logic [3:0]       ex_alusel,
   output logic [REGW-1:0]  ex_dst,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic [WIDTH-1:0] ex_store_data
);

`ifdef FORWARDING_EN
   localparam logic FWD_ON = 1'b1;
`else
   localparam logic FWD_ON = 1'b0;
`endif

   localparam logic [REGW-1:0]  ZERO_IDX = {REGW{1'b0}};
   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

   ex_ctrl_t         ctrl_r;
   logic [REGW-1:0]  dst_r;
   logic [REGW-1:0]  rs_r;
   logic [REGW-1:0]  rt_r;
   logic [WIDTH-1:0] rs_val_r;
   logic [WIDTH-1:0] rt_val_r;
   logic [WIDTH-1:0] imm_r;
   logic             alusrc_r;

   logic             ex_hit_s;
   logic             mem_hit_s;
   logic             hazard_s;
   logic             bubble_s;
   logic [WIDTH-1:0] a_fwd_s;
   logic [WIDTH-1:0] b_fwd_s;

   // Does ID read a register that an older in-flight instruction will write?
   always_comb begin
      ex_hit_s  = 1'b0;
      mem_hit_s = 1'b0;
      hazard_s  = 1'b0;
      if (ctrl_r.valid && (dst_r != ZERO_IDX) && ((dst_r == id_rs) || (dst_r == id_rt))) begin
         ex_hit_s = 1'b1;
      end else begin
         ex_hit_s = 1'b0;
      end
      if (mem_regwrite && (mem_dst != ZERO_IDX) && ((mem_dst == id_rs) || (mem_dst == id_rt))) begin
         mem_hit_s = 1'b1;
      end else begin
         mem_hit_s = 1'b0;
      end
      // With forwarding only a load in EX is too late; without it, EX and MEM
      // producers must drain to WB (regfile writes before it is read).
      if (!id_valid) begin
         hazard_s = 1'b0;
      end else if (FWD_ON) begin
         hazard_s = ex_hit_s && ctrl_r.memread;
      end else begin
         hazard_s = (ex_hit_s && ctrl_r.regwrite) || mem_hit_s;
      end
   end

   // Flush overrides stall; any of flush, stall or an empty ID slot yields a bubble
   always_comb begin
      id_stall = hazard_s && !flush;
      bubble_s = flush || hazard_s || !id_valid;
   end

   // ID/EX register: capture a real instruction, otherwise clear control and hold data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_r   <= CTRL_BUBBLE;
         dst_r    <= ZERO_IDX;
         rs_r     <= ZERO_IDX;
         rt_r     <= ZERO_IDX;
         rs_val_r <= ZERO_VAL;
         rt_val_r <= ZERO_VAL;
         imm_r    <= ZERO_VAL;
         alusrc_r <= 1'b0;
      end else if (bubble_s) begin
         ctrl_r   <= CTRL_BUBBLE;
      end else begin
         ctrl_r   <= '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread,
                       memwrite: id_memwrite, alusel: id_alusel};
         dst_r    <= id_dst;
         rs_r     <= id_rs;
         rt_r     <= id_rt;
         rs_val_r <= id_rs_val;
         rt_val_r <= id_rt_val;
         imm_r    <= id_imm;
         alusrc_r <= id_alusrc;
      end
   end

   // rs operand; forwarding tags are masked off when the feature is disabled
   fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rs (
      .idx          (rs_r),
      .reg_val      (rs_val_r),
      .mem_regwrite (mem_regwrite & FWD_ON),
      .mem_dst      (mem_dst),
      .mem_result   (mem_result),
      .wb_regwrite  (wb_regwrite & FWD_ON),
      .wb_dst       (wb_dst),
      .wb_result    (wb_result),
      .val          (a_fwd_s)
   );

   // rt operand, shared by ALU b and store data
   fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rt (
      .idx          (rt_r),
      .reg_val      (rt_val_r),
      .mem_regwrite (mem_regwrite & FWD_ON),
      .mem_dst      (mem_dst),
      .mem_result   (mem_result),
      .wb_regwrite  (wb_regwrite & FWD_ON),
      .wb_dst       (wb_dst),
      .wb_result    (wb_result),
      .val          (b_fwd_s)
   );

   assign ex_valid      = ctrl_r.valid;
   assign ex_regwrite   = ctrl_r.regwrite;
   assign ex_memread    = ctrl_r.memread;
   assign ex_memwrite   = ctrl_r.memwrite;
   assign ex_alusel     = ctrl_r.alusel;
   assign ex_dst        = dst_r;
   assign ex_a          = a_fwd_s;
   assign ex_b          = alusrc_r ? imm_r : b_fwd_s;
   assign ex_store_data = b_fwd_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the EX slot.
// Works for both builds; FORWARDING_EN selects the matching model rules.
module tb_id_ex_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic        id_alusrc;
   logic [3:0]  id_alusel;
   logic        id_regwrite, id_memread, id_memwrite;
   logic        flush;
   logic        mem_regwrite;
   logic [4:0]  mem_dst;
   logic [31:0] mem_result;
   logic        wb_regwrite;
   logic [4:0]  wb_dst;
   logic [31:0] wb_result;
   logic        id_stall, ex_valid;
   logic [31:0] ex_a, ex_b, ex_store_data;
   logic [3:0]  ex_alusel;
   logic [4:0]  ex_dst;
   logic        ex_regwrite, ex_memread, ex_memwrite;

   int checks = 0;
   int errors = 0;

   // Model of the instruction sitting in EX
   logic        m_valid, m_rw, m_mr, m_mw, m_alusrc;
   logic [3:0]  m_alusel;
   logic [4:0]  m_dst, m_rs, m_rt;
   logic [31:0] m_rsv, m_rtv, m_imm;
   logic        last_stall;
   logic        auto_mem;
`ifdef FORWARDING_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dst(id_dst), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_alusrc(id_alusrc), .id_alusel(id_alusel), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
      .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
      .ex_alusel(ex_alusel), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Newest writer of a register wins; r0 is hard-wired and never overridden
   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regv);
      if (FWD && mem_regwrite && mem_dst != 5'd0 && mem_dst == idx) return mem_result;
      if (FWD && wb_regwrite && wb_dst != 5'd0 && wb_dst == idx) return wb_result;
      return regv;
   endfunction

   // Must ID wait because a source register is not yet obtainable?
   function automatic logic exp_stall();
      logic ex_dep, mem_dep;
      if (!id_valid || flush) return 1'b0;
      ex_dep  = m_valid && m_dst != 5'd0 && (m_dst == id_rs || m_dst == id_rt);
      mem_dep = mem_regwrite && mem_dst != 5'd0 && (mem_dst == id_rs || mem_dst == id_rt);
      if (FWD) return ex_dep && m_mr;
      return (ex_dep && m_rw) || mem_dep;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_alusrc = 1'b0;
      m_alusel = ALU_CLR; m_dst = 5'd0; m_rs = 5'd0; m_rt = 5'd0;
      m_rsv = 32'd0; m_rtv = 32'd0; m_imm = 32'd0;
   endtask

   task automatic check_outputs();
      logic [31:0] rt_op;
      rt_op = operand(m_rt, m_rtv);
      chk("id_stall", {31'd0, id_stall}, {31'd0, exp_stall()});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("ex_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, {29'd0, m_rw, m_mr, m_mw});
      chk("ex_alusel", {28'd0, ex_alusel}, {28'd0, m_alusel});
      chk("ex_dst", {27'd0, ex_dst}, {27'd0, m_dst});
      chk("ex_a", ex_a, operand(m_rs, m_rsv));
      chk("ex_b", ex_b, m_alusrc ? m_imm : rt_op);
      chk("ex_store", ex_store_data, rt_op);
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic [3:0] op, input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst; id_rs_val = rsv; id_rt_val = rtv;
      id_imm = 32'h0000_0010; id_alusrc = 1'b0; id_alusel = op;
      id_regwrite = rw; id_memread = mr; id_memwrite = 1'b0;
   endtask

   // One cycle: check settled outputs, clock, advance the model, return at negedge
   task automatic step();
      logic st, old_w;
      logic [4:0] old_d;
      #1;
      check_outputs();
      st = exp_stall();
      last_stall = st;
      old_w = m_valid && m_rw;
      old_d = m_dst;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else if (flush || st || !id_valid) begin
         m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_alusel = ALU_CLR;
      end else begin
         m_valid = 1'b1; m_rw = id_regwrite; m_mr = id_memread; m_mw = id_memwrite;
         m_alusel = id_alusel; m_dst = id_dst; m_rs = id_rs; m_rt = id_rt;
         m_rsv = id_rs_val; m_rtv = id_rt_val; m_imm = id_imm; m_alusrc = id_alusrc;
      end
      @(negedge clk);
      if (auto_mem) begin
         wb_regwrite = mem_regwrite; wb_dst = mem_dst; wb_result = mem_result;
         mem_regwrite = old_w; mem_dst = old_d; mem_result = 32'hA000_0000 + {27'd0, old_d};
      end
   endtask

   task automatic drain();
      auto_mem = 1'b1; flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0);
      repeat (3) step();
   endtask

   // Step until ID is accepted; returns number of stalled cycles
   task automatic run_until_accepted(output int n);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (!last_stall) break;
         n++;
      end
      chk("stall_bound", {31'd0, last_stall}, 32'd0);
   endtask

   initial begin
      int n;
      model_reset();
      auto_mem = 1'b0; last_stall = 1'b0;
      reset = 1'b1; flush = 1'b0;
      mem_regwrite = 1'b0; mem_dst = 5'd0; mem_result = 32'd0;
      wb_regwrite = 1'b0; wb_dst = 5'd0; wb_result = 32'd0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0);

      // 1: reset state, then a simple add
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      chk("rst_alusel", {28'd0, ex_alusel}, {28'd0, 4'b1111});
      chk("rst_stall", {31'd0, id_stall}, 32'd0);
      reset = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, ALU_ADD, 1'b1, 1'b0);
      step();
      #1;
      chk("t1_a", ex_a, 32'd5);
      chk("t1_b", ex_b, 32'd7);
      chk("t1_alusel", {28'd0, ex_alusel}, {28'd0, 4'b0010});

      // 2: MEM beats WB; dropping MEM exposes WB
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0);
      mem_regwrite = 1'b1; mem_dst = 5'd1; mem_result = 32'd99;
      wb_regwrite = 1'b1; wb_dst = 5'd1; wb_result = 32'd42;
      #1;
      check_outputs();
      chk("t2_mem_prio", ex_a, FWD ? 32'd99 : 32'd5);
      mem_regwrite = 1'b0;
      #1;
      check_outputs();
      chk("t2_wb", ex_a, FWD ? 32'd42 : 32'd5);
      step();

      // 3: load-use
      drain();
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, ALU_ADD, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd3, 5'd2, 5'd5, 32'd11, 32'd12, ALU_SUB, 1'b1, 1'b0);
      #1;
      chk("t3_stall", {31'd0, id_stall}, 32'd1);
      step();
      chk("t3_bubble", {31'd0, ex_valid}, 32'd0);
      run_until_accepted(n);
      chk("t3_stall_cycles", n, FWD ? 32'd0 : 32'd1);
      chk("t3_capture", {27'd0, ex_dst}, 32'd5);

      // 4: r0 is never forwarded
      drain();
      auto_mem = 1'b0;
      set_id(1'b1, 5'd0, 5'd2, 5'd6, 32'h55, 32'd9, ALU_ADD, 1'b1, 1'b0);
      step();
      mem_regwrite = 1'b1; mem_dst = 5'd0; mem_result = 32'hFFFF;
      wb_regwrite = 1'b1; wb_dst = 5'd0; wb_result = 32'hFFFF;
      #1;
      chk("t4_r0", ex_a, 32'h55);

      // 5: flush wins over load-use stall
      drain();
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, ALU_ADD, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd3, 5'd3, 5'd4, 32'd1, 32'd2, ALU_ADD, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      chk("t5_stall", {31'd0, id_stall}, 32'd0);
      step();
      chk("t5_bubble", {31'd0, ex_valid}, 32'd0);
      flush = 1'b0;

      // 6: ALU result dependency
      drain();
      set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, ALU_ADD, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd4, 5'd1, 5'd7, 32'd3, 32'd1, ALU_ADD, 1'b1, 1'b0);
      run_until_accepted(n);
      chk("t6_stall_cycles", n, FWD ? 32'd0 : 32'd2);
      chk("t6_valid", {31'd0, ex_valid}, 32'd1);

      // Reset in the middle of a stall
      drain();
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, ALU_ADD, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd3, 5'd0, 5'd5, 32'd1, 32'd2, ALU_ADD, 1'b1, 1'b0);
      #1;
      chk("rs_stall_before", {31'd0, id_stall}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      chk("rs_stall_drop", {31'd0, id_stall}, 32'd0);
      chk("rs_valid", {31'd0, ex_valid}, 32'd0);
      chk("rs_alusel", {28'd0, ex_alusel}, {28'd0, 4'b1111});
      step();
      reset = 1'b0;

      // Random traffic with small register range to provoke hazards
      auto_mem = 1'b0;
      for (int i = 0; i < 400; i++) begin
         id_valid = ($urandom_range(3, 0) != 0);
         id_rs = 5'($urandom_range(3, 0));
         id_rt = 5'($urandom_range(3, 0));
         id_dst = 5'($urandom_range(3, 0));
         id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
         id_alusrc = 1'($urandom); id_alusel = 4'($urandom);
         id_regwrite = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
         flush = ($urandom_range(7, 0) == 0);
         mem_regwrite = 1'($urandom); mem_dst = 5'($urandom_range(3, 0)); mem_result = $urandom;
         wb_regwrite = 1'($urandom); wb_dst = 5'($urandom_range(3, 0)); wb_result = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
